// File: rtl/ttm_trace_uart_if.sv
// Trace capture bus between the Turing-machine core and the trace UART.
//   ena         : capture enable (core side drives)
//   trace_valid : one-cycle strobe qualifying trace_data
//   trace_data  : status byte for the current machine step
//   halted      : level, core is halted
interface ttm_trace_uart_if;
  logic       ena;
  logic       trace_valid;
  logic [7:0] trace_data;
  logic       halted;

  modport master (output ena, output trace_valid, output trace_data, output halted);
  modport slave  (input  ena, input  trace_valid, input  trace_data, input  halted);
endinterface

// File: rtl/ttm_trace_uart.sv
// Trace UART: captures one status byte per machine step into a small FIFO,
// queues a halt marker on a halt rising edge, and serialises the FIFO as 8N1.
//   clk, rst_n    : clock, asynchronous active-low reset
//   trace         : capture bus (slave side)
//   clr_overflow  : synchronous clear of the sticky overflow flag
//   uart_tx       : serial line, idle high
//   tx_busy       : high while a frame is on the line
//   overflow      : sticky, a byte was dropped on a full FIFO
//   fifo_count    : current FIFO occupancy
module ttm_trace_uart #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DEPTH_LOG2   = 3,
  parameter logic [7:0]  HALT_MARKER  = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ttm_trace_uart_if.slave       trace,
  input  logic                  clr_overflow,
  output logic                  uart_tx,
  output logic                  tx_busy,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   fifo_count
);

  localparam int unsigned PW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned BCW   = 12;
  localparam logic [BCW-1:0] BIT_RELOAD = BCW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  FULL_CNT   = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // FIFO and capture state
  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_halted_q;
  logic          r_halt_pending;
  logic          r_overflow;

  // Transmitter state
  state_t         r_state;
  logic [BCW-1:0] r_bit_cnt;
  logic [2:0]     r_bit_idx;
  logic [7:0]     r_shift;
  logic           r_tx;
  logic           r_busy;

  // Transmitter next-state values
  state_t         w_state_n;
  logic [BCW-1:0] w_bit_cnt_n;
  logic [2:0]     w_bit_idx_n;
  logic [7:0]     w_shift_n;
  logic           w_tx_n;
  logic           w_busy_n;
  logic           w_pop;

  logic          w_halt_edge;
  logic          w_data_sel;
  logic          w_marker_sel;
  logic          w_wr_req;
  logic [7:0]    w_wr_data;
  logic          w_full;
  logic          w_wr_ok;
  logic          w_drop;
  logic          w_not_empty;
  logic [7:0]    w_head;
  logic [2:0]    w_bit_idx_inc;

  // Write arbitration: trace data beats a pending halt marker
  assign w_halt_edge  = trace.ena & trace.halted & ~r_halted_q;
  assign w_data_sel   = trace.ena & trace.trace_valid;
  assign w_marker_sel = ~w_data_sel & r_halt_pending;
  assign w_wr_req     = w_data_sel | w_marker_sel;
  assign w_wr_data    = w_data_sel ? trace.trace_data : HALT_MARKER;
  assign w_full       = (r_count == FULL_CNT);
  // A same-cycle pop frees a slot, so a full FIFO still accepts the write
  assign w_wr_ok      = w_wr_req & (~w_full | w_pop);
  assign w_drop       = w_wr_req & w_full & ~w_pop;
  assign w_not_empty  = (r_count != '0);
  assign w_head       = r_mem[r_rd_ptr];
  assign w_bit_idx_inc = r_bit_idx + 3'd1;

  // FIFO storage, no reset needed on the data array
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= w_wr_data;
    end
  end

  // FIFO pointers, occupancy, halt detect and overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_halted_q     <= 1'b0;
      r_halt_pending <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      r_halted_q     <= trace.halted;
      // A dropped marker still consumes the pending request
      r_halt_pending <= w_halt_edge | (r_halt_pending & ~w_marker_sel);
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_wr_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // Set takes priority over clear
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Transmitter state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_bit_cnt <= w_bit_cnt_n;
      r_bit_idx <= w_bit_idx_n;
      r_shift   <= w_shift_n;
      r_tx      <= w_tx_n;
      r_busy    <= w_busy_n;
    end
  end

  // Transmitter next-state: the line value is computed one cycle ahead so uart_tx is a flop
  always_comb begin
    w_state_n   = r_state;
    w_bit_cnt_n = r_bit_cnt;
    w_bit_idx_n = r_bit_idx;
    w_shift_n   = r_shift;
    w_tx_n      = r_tx;
    w_busy_n    = r_busy;
    w_pop       = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_tx_n   = 1'b1;
        w_busy_n = 1'b0;
        if (w_not_empty) begin
          w_pop       = 1'b1;
          w_shift_n   = w_head;
          w_state_n   = S_START;
          w_bit_cnt_n = BIT_RELOAD;
          w_tx_n      = 1'b0;
          w_busy_n    = 1'b1;
        end
      end
      S_START: begin
        if (r_bit_cnt == '0) begin
          w_state_n   = S_DATA;
          w_bit_idx_n = 3'd0;
          w_bit_cnt_n = BIT_RELOAD;
          w_tx_n      = r_shift[0];
        end else begin
          w_bit_cnt_n = r_bit_cnt - BCW'(1);
        end
      end
      S_DATA: begin
        if (r_bit_cnt == '0) begin
          w_bit_cnt_n = BIT_RELOAD;
          if (r_bit_idx == 3'd7) begin
            w_state_n = S_STOP;
            w_tx_n    = 1'b1;
          end else begin
            w_bit_idx_n = w_bit_idx_inc;
            w_tx_n      = r_shift[w_bit_idx_inc];
          end
        end else begin
          w_bit_cnt_n = r_bit_cnt - BCW'(1);
        end
      end
      S_STOP: begin
        if (r_bit_cnt == '0) begin
          // Chain straight into the next start bit when more data is queued
          if (w_not_empty) begin
            w_pop       = 1'b1;
            w_shift_n   = w_head;
            w_state_n   = S_START;
            w_bit_cnt_n = BIT_RELOAD;
            w_tx_n      = 1'b0;
          end else begin
            w_state_n = S_IDLE;
            w_tx_n    = 1'b1;
            w_busy_n  = 1'b0;
          end
        end else begin
          w_bit_cnt_n = r_bit_cnt - BCW'(1);
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_tx_n    = 1'b1;
        w_busy_n  = 1'b0;
      end
    endcase
  end

  assign uart_tx    = r_tx;
  assign tx_busy    = r_busy;
  assign overflow   = r_overflow;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_ttm_trace_uart.sv
// Bench for ttm_trace_uart: directed scenarios plus random traffic, with a
// queue-based reference model compared against the DUT every cycle.
module tb_ttm_trace_uart;

  localparam int unsigned CPB   = 16;
  localparam int unsigned DL2   = 3;
  localparam int unsigned DEPTH = 1 << DL2;
  localparam logic [7:0]  MARK  = 8'hFF;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           clr_overflow = 1'b0;
  logic           uart_tx;
  logic           tx_busy;
  logic           overflow;
  logic [DL2:0]   fifo_count;

  ttm_trace_uart_if u_if();

  ttm_trace_uart #(
    .CLKS_PER_BIT (CPB),
    .DEPTH_LOG2   (DL2),
    .HALT_MARKER  (MARK)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .trace        (u_if),
    .clr_overflow (clr_overflow),
    .uart_tx      (uart_tx),
    .tx_busy      (tx_busy),
    .overflow     (overflow),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // FIFO as a queue; the transmitter is "busy for 10*CPB cycles from the pop".
  logic [7:0] q[$];
  bit         m_busy;
  int         m_t;
  logic [7:0] m_byte;
  bit         m_pend;
  bit         m_hq;
  bit         m_ovf;
  bit         m_wr;
  bit         m_edge;
  logic [7:0] m_wb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_busy = 0; m_t = 0; m_byte = 8'h00;
      m_pend = 0; m_hq = 0; m_ovf = 0;
    end else begin
      if (m_busy) begin
        m_t++;
        if (m_t == int'(10 * CPB)) m_busy = 0;
      end
      if (!m_busy && q.size() > 0) begin
        m_byte = q.pop_front();
        m_busy = 1;
        m_t    = 0;
      end
      m_edge = u_if.ena && u_if.halted && !m_hq;
      m_wr   = 0;
      m_wb   = 8'h00;
      if (u_if.ena && u_if.trace_valid) begin
        m_wr = 1; m_wb = u_if.trace_data;
      end else if (m_pend) begin
        m_wr = 1; m_wb = MARK; m_pend = 0;
      end
      if (m_edge) m_pend = 1;
      m_hq = u_if.halted;
      if (m_wr && q.size() >= int'(DEPTH)) m_ovf = 1;
      else begin
        if (m_wr) q.push_back(m_wb);
        if (clr_overflow) m_ovf = 0;
      end
    end
  end

  function automatic int exp_tx();
    int b;
    if (!m_busy) return 1;
    b = m_t / int'(CPB);
    if (b == 0) return 0;
    if (b >= 9) return 1;
    return int'(m_byte[b-1]);
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("model_uart_tx",    int'(uart_tx),    exp_tx());
    chk("model_tx_busy",    int'(tx_busy),    int'(m_busy));
    chk("model_overflow",   int'(overflow),   int'(m_ovf));
    chk("model_fifo_count", int'(fifo_count), q.size());
  end

  // Length of the most recent contiguous tx_busy stretch
  int busy_run = 0;
  int last_run = 0;
  always @(negedge clk) begin
    if (tx_busy) busy_run++;
    else if (busy_run != 0) begin
      last_run = busy_run;
      busy_run = 0;
    end
  end

  // Line receiver: samples each bit at its centre
  task automatic rx_byte(input logic [7:0] exp, input string name);
    bit         found;
    logic [7:0] b;
    found = 0;
    b     = 8'h00;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (uart_tx == 1'b0) begin
        found = 1;
        break;
      end
    end
    chk({name, "_start_seen"}, int'(found), 1);
    if (found) begin
      repeat (CPB / 2) @(negedge clk);
      chk({name, "_start_bit"}, int'(uart_tx), 0);
      for (int k = 0; k < 8; k++) begin
        repeat (CPB) @(negedge clk);
        b[k] = uart_tx;
      end
      repeat (CPB) @(negedge clk);
      chk({name, "_stop_bit"}, int'(uart_tx), 1);
      chk({name, "_byte"}, int'(b), int'(exp));
    end
  endtask

  task automatic strobe(input logic [7:0] d);
    u_if.trace_valid = 1'b1;
    u_if.trace_data  = d;
    @(negedge clk);
    u_if.trace_valid = 1'b0;
  endtask

  initial begin
    u_if.ena         = 1'b1;
    u_if.trace_valid = 1'b0;
    u_if.trace_data  = 8'h00;
    u_if.halted      = 1'b0;

    // Reset values
    #1 rst_n = 1'b0;
    #1;
    chk("rst_uart_tx",    int'(uart_tx),    1);
    chk("rst_tx_busy",    int'(tx_busy),    0);
    chk("rst_overflow",   int'(overflow),   0);
    chk("rst_fifo_count", int'(fifo_count), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single byte A5
    u_if.trace_valid = 1'b1;
    u_if.trace_data  = 8'hA5;
    @(negedge clk);
    u_if.trace_valid = 1'b0;
    chk("single_count_one", int'(fifo_count), 1);
    rx_byte(8'hA5, "single");
    chk("single_count_zero", int'(fifo_count), 0);
    repeat (20) @(negedge clk);
    chk("single_busy_len", last_run, 160);

    // Burst of three back-to-back frames
    fork
      begin
        u_if.trace_valid = 1'b1;
        u_if.trace_data  = 8'h01;
        @(negedge clk);
        u_if.trace_data  = 8'h02;
        @(negedge clk);
        u_if.trace_data  = 8'h03;
        @(negedge clk);
        u_if.trace_valid = 1'b0;
        chk("burst_peak_count", int'(fifo_count), 2);
      end
      begin
        rx_byte(8'h01, "burst0");
        rx_byte(8'h02, "burst1");
        rx_byte(8'h03, "burst2");
      end
    join
    repeat (20) @(negedge clk);
    chk("burst_busy_len", last_run, 480);

    // Overflow: twelve strobes, nine frames survive
    fork
      begin
        u_if.trace_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
          u_if.trace_data = 8'(8'h10 + i);
          @(negedge clk);
        end
        u_if.trace_valid = 1'b0;
        chk("ovf_flag_set", int'(overflow), 1);
        chk("ovf_count_full", int'(fifo_count), 8);
      end
      begin
        for (int i = 0; i < 9; i++) rx_byte(8'(8'h10 + i), "ovf_frame");
      end
    join
    repeat (200) @(negedge clk);
    chk("ovf_no_tenth_frame", int'(tx_busy), 0);
    chk("ovf_busy_len", last_run, 9 * 160);
    chk("ovf_flag_sticky", int'(overflow), 1);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    chk("ovf_flag_cleared", int'(overflow), 0);

    // Halt ordering: data byte first, then one marker
    u_if.trace_valid = 1'b1;
    u_if.trace_data  = 8'h42;
    u_if.halted      = 1'b1;
    @(negedge clk);
    u_if.trace_valid = 1'b0;
    rx_byte(8'h42, "halt_data");
    rx_byte(MARK, "halt_marker");
    repeat (100) @(negedge clk);
    chk("halt_no_second_marker", int'(tx_busy), 0);
    chk("halt_busy_len", last_run, 320);
    u_if.halted = 1'b0;
    repeat (5) @(negedge clk);

    // ena low: queued byte drains, nothing new is captured
    fork
      begin
        u_if.trace_valid = 1'b1;
        u_if.trace_data  = 8'h5A;
        @(negedge clk);
        u_if.ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
          u_if.trace_data = 8'(8'hC0 + i);
          if (i == 4) u_if.halted = 1'b1;
          @(negedge clk);
        end
        u_if.trace_valid = 1'b0;
        chk("ena_low_nothing_queued", int'(fifo_count), 0);
      end
      rx_byte(8'h5A, "ena_low_drain");
    join
    repeat (100) @(negedge clk);
    chk("ena_low_busy_len", last_run, 160);
    chk("ena_low_idle", int'(tx_busy), 0);
    u_if.halted = 1'b0;
    @(negedge clk);
    u_if.ena = 1'b1;
    repeat (5) @(negedge clk);

    // Reset mid-frame during data bit 3
    strobe(8'h3C);
    @(negedge clk);
    repeat (70) @(negedge clk);
    chk("midrst_in_frame", int'(tx_busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_uart_tx",    int'(uart_tx),    1);
    chk("midrst_tx_busy",    int'(tx_busy),    0);
    chk("midrst_fifo_count", int'(fifo_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("midrst_line_idle", int'(uart_tx), 1);
    chk("midrst_busy_idle", int'(tx_busy), 0);

    // Random traffic against the model
    for (int c = 0; c < 6000; c++) begin
      u_if.trace_valid = ($urandom_range(0, 99) < 5);
      u_if.trace_data  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 99) < 2) u_if.halted = ~u_if.halted;
      if ((c % 64) == 0) u_if.ena = ($urandom_range(0, 99) < 80);
      clr_overflow = ($urandom_range(0, 99) < 2);
      @(negedge clk);
    end
    u_if.trace_valid = 1'b0;
    clr_overflow     = 1'b0;
    u_if.ena         = 1'b1;
    repeat (2000) @(negedge clk);
    chk("final_drained", int'(fifo_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ttm_trace_uart.md
Name: ttm_trace_uart

Overview:
- Reader end of the Turing-machine core's status output: samples one status byte per machine step into a small FIFO.
- Serialises the FIFO contents off-chip as 8N1 UART so a host can reconstruct the execution trace.
- Appends a halt marker byte when the core reports halt.
- Sits beside the core inside the top level. Inputs come from the core's step strobe, status byte and halt flag. The output drives one uio pin.

Parameters:
- CLKS_PER_BIT, default 16: clock cycles per UART bit; legal range 4..4095.
- DEPTH_LOG2, default 3: FIFO depth is 2**DEPTH_LOG2 entries (default 8).
- HALT_MARKER, default 8'hFF: byte enqueued on a halt rising edge.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  capture enable; when low, no new bytes are enqueued and transmission continues.
- trace_valid  in  1  single-cycle strobe: trace_data is valid this cycle.
- trace_data  in  8  status byte from the core.
- halted  in  1  level: core is halted.
- clr_overflow  in  1  synchronous clear of the overflow flag.
- uart_tx  out  1  serial output, idle high.
- tx_busy  out  1  high while a frame is on the line.
- overflow  out  1  sticky: a byte was dropped.
- fifo_count  out  DEPTH_LOG2+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync deassert handled upstream) forces these values immediately, regardless of clock:
  - uart_tx=1, tx_busy=0, overflow=0, fifo_count=0.
  - FIFO pointers=0, halt_pending=0, halted_q=0.
- Reset mid-frame aborts the frame. The line returns high immediately.
- Halt detect:
  - halted_q is a register of halted.
  - A rising edge (halted & ~halted_q), sampled while ena=1, sets halt_pending.
  - Only a rising edge counts; a halted level held high does not re-set halt_pending.
- FIFO write, at most one per cycle, in priority order:
  1. ena & trace_valid: write trace_data.
  2. Otherwise, if halt_pending: write HALT_MARKER and clear halt_pending.
- Consequence of the priority: trace_valid coincident with the halt edge gives the data byte first, then the marker on a later idle cycle.
- Full FIFO (fifo_count == 2**DEPTH_LOG2):
  - The write is dropped and overflow is set.
  - A dropped marker still clears halt_pending.
- A write and a pop in the same cycle are both allowed. If the FIFO is full, the pop frees the slot and the write succeeds, with no overflow.
- overflow clears only on clr_overflow=1 or reset. If set and clear happen in the same cycle, set wins.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if fifo_count>0, pop the head into shift_reg, go to START, tx_busy=1. The pop and fifo_count decrement happen in that same cycle.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: uart_tx=shift_reg[bit index], LSB first, each bit for CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles.
  - Leaving STOP: if fifo_count>0, pop and go straight to START, giving back-to-back frames with no idle gap. Otherwise go to IDLE with tx_busy=0.
- Timing:
  - uart_tx is registered.
  - Start bit begins the cycle after the pop.
  - One frame is exactly 10*CLKS_PER_BIT cycles.
- Bit counter is a 12-bit down-counter, reloaded with CLKS_PER_BIT-1 on each bit boundary.
- ena low does not affect the TX FSM; queued bytes still drain.
- fifo_count has DEPTH_LOG2+1 bits. Pointers wrap modulo 2**DEPTH_LOG2.

Test Plan:
- Reset, then single byte: trace_valid with 8'hA5 -> fifo_count 1 for one cycle, then 0. uart_tx shows 0,1,0,1,0,0,1,0,1,1 at 16 cycles per bit. tx_busy high for exactly 160 cycles.
- Burst: 3 strobes on consecutive cycles, bytes 01,02,03 -> three contiguous frames totalling 480 cycles with no high gap between stop and the next start. fifo_count peaks at 2.
- Overflow: 12 strobes of 8'h10..8'h1B in consecutive cycles while TX is idle at start -> overflow=1 and exactly 9 frames (10..18). clr_overflow pulse -> overflow=0.
- Halt ordering: trace_valid with 8'h42 in the same cycle as halted rising -> frames 42 then FF. halted held high for 100 cycles -> no second FF.
- ena low: strobes and a halt edge while ena=0 -> nothing enqueued. A byte queued before ena fell still transmits fully.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 -> uart_tx=1, tx_busy=0, fifo_count=0 with no clock edge. After release, the line stays idle.
